// File: rtl/alu_operand_stage.sv
// Decode/operand-fetch stage ahead of the 16-bit ALU: splits the instruction word, reads the
// register file with writeback bypass, and stalls on pending-write hazards.
module alu_operand_stage #(
    parameter int NREGS = 8,
    parameter int DW    = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [15:0]   instr,
    output logic          ex_valid,
    input  logic          ex_ready,
    output logic [2:0]    op1,
    output logic [2:0]    op2,
    output logic [DW-1:0] a,
    output logic [DW-1:0] b,
    output logic [2:0]    ex_rd,
    input  logic          wb_en,
    input  logic [2:0]    wb_addr,
    input  logic [DW-1:0] wb_data
);

    // Handshakes: a transfer happens on a rising edge where valid && ready; a producer holds its
    // payload stable while valid && !ready, and in_ready never looks at in_valid.

    logic [DW-1:0]    rf_q [NREGS];
    logic [DW-1:0]    rf_d [NREGS];
    logic [NREGS-1:0] pending_q, pending_d;
    logic             ex_valid_q, ex_valid_d;
    logic [2:0]       op1_q, op1_d, op2_q, op2_d, ex_rd_q, ex_rd_d;
    logic [DW-1:0]    a_q, a_d, b_q, b_d;

    logic [2:0]       dec_op1, dec_rd, dec_ra, dec_rb, dec_op2;
    logic             reads_a, reads_b, hazard, accept;
    logic [NREGS-1:0] pend_eff;
    logic [DW-1:0]    ra_val, rb_val, a_src, b_src;
    logic             instr_unused;

    assign instr_unused = instr[0];

    always_comb begin
        dec_op1 = instr[15:13];
        dec_rd  = instr[12:10];
        dec_ra  = instr[9:7];
        dec_rb  = instr[6:4];
        dec_op2 = instr[3:1];

        reads_a = (dec_op1 != 3'b101) && (dec_op1 != 3'b111);
        reads_b = (dec_op1 != 3'b101) && (dec_op1 != 3'b110);

        // A register being written back this cycle is no longer outstanding.
        for (int i = 0; i < NREGS; i++) begin
            pend_eff[i] = pending_q[i] && !(wb_en && (wb_addr == 3'(i)));
        end

        ra_val = (wb_en && (wb_addr == dec_ra)) ? wb_data : rf_q[dec_ra];
        rb_val = (wb_en && (wb_addr == dec_rb)) ? wb_data : rf_q[dec_rb];

        case (dec_op1)
            3'b101: begin
                a_src = {{(DW-10){1'b0}}, instr[9:0]};
                b_src = '0;
            end
            3'b111: begin
                a_src = '0;
                b_src = rb_val;
            end
            3'b110: begin
                a_src = ra_val;
                b_src = '0;
            end
            default: begin
                a_src = ra_val;
                b_src = rb_val;
            end
        endcase

        hazard   = (reads_a && pend_eff[dec_ra]) || (reads_b && pend_eff[dec_rb])
                 || pend_eff[dec_rd];
        in_ready = (!ex_valid_q || ex_ready) && !hazard;
        accept   = in_valid && in_ready;

        rf_d       = rf_q;
        pending_d  = pending_q;
        ex_valid_d = ex_valid_q;
        op1_d      = op1_q;
        op2_d      = op2_q;
        a_d        = a_q;
        b_d        = b_q;
        ex_rd_d    = ex_rd_q;

        if (wb_en) begin
            rf_d[wb_addr]      = wb_data;
            pending_d[wb_addr] = 1'b0;
        end

        if (accept) begin
            pending_d[dec_rd] = 1'b1;
            ex_valid_d        = 1'b1;
            op1_d             = dec_op1;
            op2_d             = dec_op2;
            a_d               = a_src;
            b_d               = b_src;
            ex_rd_d           = dec_rd;
        end else if (ex_ready) begin
            ex_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                rf_q[i] <= '0;
            end
            pending_q  <= '0;
            ex_valid_q <= 1'b0;
            op1_q      <= '0;
            op2_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            ex_rd_q    <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                rf_q[i] <= rf_d[i];
            end
            pending_q  <= pending_d;
            ex_valid_q <= ex_valid_d;
            op1_q      <= op1_d;
            op2_q      <= op2_d;
            a_q        <= a_d;
            b_q        <= b_d;
            ex_rd_q    <= ex_rd_d;
        end
    end

    assign ex_valid = ex_valid_q;
    assign op1      = op1_q;
    assign op2      = op2_q;
    assign a        = a_q;
    assign b        = b_q;
    assign ex_rd    = ex_rd_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Bench for alu_operand_stage: directed vectors, a behavioural register-file/scoreboard model
// compared every cycle, and literal expectations at the interesting points.
module tb_alu_operand_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] instr;
    logic        ex_valid;
    logic        ex_ready;
    logic [2:0]  op1, op2, ex_rd;
    logic [15:0] a, b;
    logic        wb_en;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;

    int checks   = 0;
    int failures = 0;

    alu_operand_stage #(.NREGS(8), .DW(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .op1(op1), .op2(op2), .a(a), .b(b),
        .ex_rd(ex_rd), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [15:0] m_reg [8];
    bit          m_pend [8];
    bit          m_known = 0;
    bit          m_ev;
    logic [2:0]  m_op1, m_op2, m_rd;
    logic [15:0] m_a, m_b;

    function automatic logic [15:0] m_read(input int r);
        if (wb_en && int'(wb_addr) == r) return wb_data;
        return m_reg[r];
    endfunction

    function automatic bit m_busy(input int r);
        return m_pend[r] && !(wb_en && int'(wb_addr) == r);
    endfunction

    function automatic bit m_ready();
        int  opc, rd, ra, rb;
        bit  use_a, use_b;
        opc   = int'(instr[15:13]);
        rd    = int'(instr[12:10]);
        ra    = int'(instr[9:7]);
        rb    = int'(instr[6:4]);
        use_a = (opc <= 4) || (opc == 6);
        use_b = (opc <= 4) || (opc == 7);
        if (m_ev && !ex_ready) return 0;
        if (use_a && m_busy(ra)) return 0;
        if (use_b && m_busy(rb)) return 0;
        if (m_busy(rd)) return 0;
        return 1;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                m_reg[i]  = 16'h0;
                m_pend[i] = 0;
            end
            m_ev = 0; m_op1 = 0; m_op2 = 0; m_rd = 0; m_a = 0; m_b = 0;
            m_known = 1;
        end else if (m_known) begin
            bit          acc;
            int          opc;
            logic [15:0] na, nb;
            acc = in_valid && m_ready();
            opc = int'(instr[15:13]);
            na  = m_read(int'(instr[9:7]));
            nb  = m_read(int'(instr[6:4]));
            if (opc == 5) begin na = {6'd0, instr[9:0]}; nb = 0; end
            if (opc == 6) nb = 0;
            if (opc == 7) na = 0;
            if (wb_en) begin
                m_reg[wb_addr]  = wb_data;
                m_pend[wb_addr] = 0;
            end
            if (acc) begin
                m_pend[instr[12:10]] = 1;
                m_ev = 1; m_op1 = instr[15:13]; m_op2 = instr[3:1]; m_rd = instr[12:10];
                m_a = na; m_b = nb;
            end else if (ex_ready) begin
                m_ev = 0;
            end
        end
    end

    // Compare process: outputs against the model once per cycle, away from the active edge.
    always @(negedge clk) begin
        if (m_known) begin
            chk("m_ex_valid", 32'(ex_valid), 32'(m_ev));
            chk("m_in_ready", 32'(in_ready), 32'(m_ready()));
            chk("m_op1", 32'(op1), 32'(m_op1));
            chk("m_op2", 32'(op2), 32'(m_op2));
            chk("m_a", 32'(a), 32'(m_a));
            chk("m_b", 32'(b), 32'(m_b));
            chk("m_ex_rd", 32'(ex_rd), 32'(m_rd));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] mk(input logic [2:0] o1, input logic [2:0] rd,
                                       input logic [2:0] ra, input logic [2:0] rb,
                                       input logic [2:0] o2);
        return {o1, rd, ra, rb, o2, 1'b0};
    endfunction

    function automatic logic [15:0] mk_ldi(input logic [2:0] rd, input logic [9:0] imm);
        return {3'b101, rd, imm};
    endfunction

    task automatic wb(input logic [2:0] addr, input logic [15:0] data);
        wb_en = 1; wb_addr = addr; wb_data = data;
        tick();
        wb_en = 0;
    endtask

    initial begin
        rst = 1; in_valid = 0; instr = 0; ex_ready = 1; wb_en = 0; wb_addr = 0; wb_data = 0;
        tick();
        tick();
        rst = 0;

        // Reset then idle
        chk("rst_ex_valid", 32'(ex_valid), 0);
        chk("rst_a", 32'(a), 0);
        chk("rst_b", 32'(b), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        in_valid = 1; instr = mk(3'd0, 3'd0, 3'd3, 3'd3, 3'd0);
        tick();
        in_valid = 0;
        chk("r3_ex_valid", 32'(ex_valid), 1);
        chk("r3_a", 32'(a), 0);
        wb(3'd0, 16'h0000);

        // LDI chain
        in_valid = 1; instr = mk_ldi(3'd2, 10'h3FF);
        tick();
        in_valid = 0;
        chk("ldi_ex_valid", 32'(ex_valid), 1);
        chk("ldi_a", 32'(a), 32'h03FF);
        chk("ldi_b", 32'(b), 0);
        chk("ldi_ex_rd", 32'(ex_rd), 2);
        chk("ldi_op1", 32'(op1), 5);
        instr = mk(3'd0, 3'd3, 3'd2, 3'd2, 3'd0);
        #1;
        chk("ldi_r2_pending", 32'(in_ready), 0);
        wb(3'd2, 16'h03FF);
        in_valid = 1;
        tick();
        in_valid = 0;
        chk("add_a", 32'(a), 32'h03FF);
        chk("add_b", 32'(b), 32'h03FF);
        wb(3'd3, 16'h07FE);

        // RAW stall released by writeback with bypass
        in_valid = 1; instr = mk_ldi(3'd1, 10'h010);
        tick();
        instr = mk(3'd0, 3'd4, 3'd1, 3'd0, 3'd0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("raw_stall", 32'(in_ready), 0);
            tick();
        end
        wb_en = 1; wb_addr = 3'd1; wb_data = 16'h1234;
        #1;
        chk("raw_release", 32'(in_ready), 1);
        tick();
        in_valid = 0; wb_en = 0;
        chk("raw_bypass_a", 32'(a), 32'h1234);
        chk("raw_b", 32'(b), 0);
        chk("raw_ex_rd", 32'(ex_rd), 4);
        wb(3'd4, 16'h00FF);

        // Backpressure
        ex_ready = 0;
        in_valid = 1; instr = mk_ldi(3'd6, 10'h055);
        tick();
        instr = mk_ldi(3'd7, 10'h066);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_in_ready", 32'(in_ready), 0);
            chk("bp_a", 32'(a), 32'h0055);
            chk("bp_ex_rd", 32'(ex_rd), 6);
            chk("bp_ex_valid", 32'(ex_valid), 1);
            tick();
        end
        ex_ready = 1;
        #1;
        chk("bp_release", 32'(in_ready), 1);
        tick();
        in_valid = 0;
        chk("bp_next_a", 32'(a), 32'h0066);
        chk("bp_next_rd", 32'(ex_rd), 7);
        tick();
        chk("bp_drain", 32'(ex_valid), 0);
        wb(3'd6, 16'h0001);
        wb(3'd7, 16'h0002);

        // op1=111 reads rb only; ra pending does not stall
        in_valid = 1; instr = mk_ldi(3'd0, 10'h012);
        tick();
        instr = mk(3'd7, 3'd3, 3'd0, 3'd4, 3'd2);
        #1;
        chk("op7_no_stall", 32'(in_ready), 1);
        tick();
        in_valid = 0;
        chk("op7_a", 32'(a), 0);
        chk("op7_b", 32'(b), 32'h00FF);
        chk("op7_op2", 32'(op2), 2);
        chk("op7_op1", 32'(op1), 7);
        wb(3'd0, 16'h0012);
        wb(3'd3, 16'h0003);

        // Simultaneous writeback and issue to R5: set wins
        in_valid = 1; instr = mk_ldi(3'd5, 10'h009);
        wb_en = 1; wb_addr = 3'd5; wb_data = 16'h0007;
        tick();
        wb_en = 0;
        instr = mk(3'd0, 3'd6, 3'd5, 3'd5, 3'd0);
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("r5_stall", 32'(in_ready), 0);
            tick();
        end
        in_valid = 0;
        wb(3'd5, 16'hABCD);
        in_valid = 1; instr = mk(3'd6, 3'd6, 3'd5, 3'd1, 3'd0);
        tick();
        in_valid = 0;
        chk("op6_a", 32'(a), 32'hABCD);
        chk("op6_b", 32'(b), 0);
        wb(3'd6, 16'h0000);

        // Reset mid-stall drops the held instruction and the scoreboard
        ex_ready = 0;
        in_valid = 1; instr = mk_ldi(3'd1, 10'h020);
        tick();
        in_valid = 0;
        rst = 1;
        tick();
        rst = 0;
        chk("mid_rst_ex_valid", 32'(ex_valid), 0);
        chk("mid_rst_a", 32'(a), 0);
        chk("mid_rst_op1", 32'(op1), 0);
        chk("mid_rst_ex_rd", 32'(ex_rd), 0);
        instr = mk(3'd0, 3'd1, 3'd2, 3'd2, 3'd0);
        #1;
        chk("mid_rst_in_ready", 32'(in_ready), 1);
        in_valid = 1; ex_ready = 1;
        tick();
        in_valid = 0;
        chk("mid_rst_r2_a", 32'(a), 0);
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
